// File: rtl/spi_record_mailbox.sv
// Sysclock-side mailbox for the SPI driver's user records: publishes each completed
// COPI record, streams one change event per modified byte, and drives the CIPO record.
module spi_record_mailbox #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned REC_BYTES   = 256
) (
   input  logic                   sysclock,
   input  logic                   sysreset,
   input  logic                   spi_ss,
   input  logic                   spi_busy,
   input  logic [8*REC_BYTES-1:0] copi_data,
   output logic [8*REC_BYTES-1:0] cipo_data,
   input  logic [8*REC_BYTES-1:0] tx_data,
   output logic [8*REC_BYTES-1:0] copi_rec,
   output logic                   rec_valid,
   output logic                   evt_valid,
   input  logic                   evt_ready,
   output logic [7:0]             evt_addr,
   output logic [7:0]             evt_data,
   output logic [7:0]             evt_old,
   output logic                   scan_done,
   output logic                   overrun,
   input  logic                   clr_overrun,
   output logic [15:0]            xfer_cnt
);
   localparam int unsigned RW       = 8*REC_BYTES;
   localparam logic [7:0]  LAST_IDX = 8'(REC_BYTES-1);

   typedef enum logic [1:0] {IDLE, CAPTURE, SCAN, DONE} state_e;
   state_e state_q, state_d;

   logic [SYNC_STAGES-1:0] ss_sync_q, busy_sync_q;
   logic                   ss_s, busy_s, busy_prev_q, busy_fall;
   logic [RW-1:0]          cipo_q, copi_rec_q, copi_rec_d, old_rec_q, old_rec_d;
   logic [7:0]             idx_q, idx_d;
   logic [15:0]            xfer_cnt_q, xfer_cnt_d;
   logic                   overrun_q, overrun_d, rec_valid_q;
   logic [7:0]             new_byte, old_byte;
   logic                   byte_diff, byte_done;

   // Chains reset to the idle line levels so reset itself never looks like a busy fall
   always_ff @(posedge sysclock or negedge sysreset) begin
      if (!sysreset) begin
         ss_sync_q   <= '1;
         busy_sync_q <= '0;
         busy_prev_q <= 1'b0;
         cipo_q      <= '0;
      end else begin
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss};
         busy_sync_q <= {busy_sync_q[SYNC_STAGES-2:0], spi_busy};
         busy_prev_q <= busy_s;
         if (ss_s) begin
            cipo_q <= tx_data;
         end
      end
   end

   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign busy_s    = busy_sync_q[SYNC_STAGES-1];
   assign busy_fall = busy_prev_q & ~busy_s;

   assign new_byte  = copi_rec_q[{idx_q, 3'b000} +: 8];
   assign old_byte  = old_rec_q[{idx_q, 3'b000} +: 8];
   assign byte_diff = (new_byte != old_byte);
   assign byte_done = (state_q == SCAN) && (!byte_diff || evt_ready);

   always_ff @(posedge sysclock or negedge sysreset) begin
      if (!sysreset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (busy_fall) state_d = CAPTURE;
         CAPTURE: state_d = SCAN;
         SCAN:    if (byte_done && (idx_q == LAST_IDX)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A busy fall outside IDLE drops that record; set takes priority over clear
   always_comb begin
      old_rec_d  = old_rec_q;
      copi_rec_d = copi_rec_q;
      xfer_cnt_d = xfer_cnt_q;
      idx_d      = idx_q;
      overrun_d  = overrun_q;
      if (state_q == CAPTURE) begin
         old_rec_d  = copi_rec_q;
         copi_rec_d = copi_data;
         xfer_cnt_d = xfer_cnt_q + 16'd1;
         idx_d      = '0;
      end else if (byte_done) begin
         idx_d = idx_q + 8'd1;
      end
      if (busy_fall && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end else if (clr_overrun) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge sysclock or negedge sysreset) begin
      if (!sysreset) begin
         old_rec_q   <= '0;
         copi_rec_q  <= '0;
         xfer_cnt_q  <= '0;
         idx_q       <= '0;
         overrun_q   <= 1'b0;
         rec_valid_q <= 1'b0;
      end else begin
         old_rec_q   <= old_rec_d;
         copi_rec_q  <= copi_rec_d;
         xfer_cnt_q  <= xfer_cnt_d;
         idx_q       <= idx_d;
         overrun_q   <= overrun_d;
         rec_valid_q <= (state_q == CAPTURE);
      end
   end

   always_comb begin
      evt_valid = (state_q == SCAN) && byte_diff;
      evt_addr  = evt_valid ? idx_q : '0;
      evt_data  = evt_valid ? new_byte : '0;
      evt_old   = evt_valid ? old_byte : '0;
      scan_done = (state_q == DONE);
      rec_valid = rec_valid_q;
      overrun   = overrun_q;
      xfer_cnt  = xfer_cnt_q;
      copi_rec  = copi_rec_q;
      cipo_data = cipo_q;
   end
endmodule

// File: tb/tb_spi_record_mailbox.sv
// Randomised scoreboard bench for spi_record_mailbox: expected change events and
// published records are queued at stimulus time and checked by a separate monitor.
module tb_spi_record_mailbox;
   localparam int unsigned SS = 2;
   localparam int unsigned NB = 256;
   localparam int unsigned RW = 8*NB;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] old;
   } evt_t;

   logic          clk = 1'b0;
   logic          rst_n, spi_ss, spi_busy, evt_ready, clr_overrun;
   logic [RW-1:0] copi_data, tx_data, cipo_data, copi_rec;
   logic          rec_valid, evt_valid, scan_done, overrun;
   logic [7:0]    evt_addr, evt_data, evt_old;
   logic [15:0]   xfer_cnt;

   int checks = 0;
   int failures = 0;
   int hs_cnt = 0;
   int stall_seen = 0;
   int stall_len = 0;
   int stall_gen = 0;
   bit rand_ready = 1'b0;
   longint t_drop = 0;

   evt_t          exp_evt[$];
   logic [RW-1:0] exp_rec_q[$];
   logic [15:0]   exp_cnt_q[$];
   logic [7:0]    model_prev[NB];
   int unsigned   model_cnt = 0;

   spi_record_mailbox #(.SYNC_STAGES(SS), .REC_BYTES(NB)) dut (
      .sysclock(clk), .sysreset(rst_n), .spi_ss(spi_ss), .spi_busy(spi_busy),
      .copi_data(copi_data), .cipo_data(cipo_data), .tx_data(tx_data),
      .copi_rec(copi_rec), .rec_valid(rec_valid), .evt_valid(evt_valid),
      .evt_ready(evt_ready), .evt_addr(evt_addr), .evt_data(evt_data),
      .evt_old(evt_old), .scan_done(scan_done), .overrun(overrun),
      .clr_overrun(clr_overrun), .xfer_cnt(xfer_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] get_byte(input logic [RW-1:0] r, input int i);
      logic [RW-1:0] t;
      t = r >> (8*i);
      return t[7:0];
   endfunction

   function automatic logic [RW-1:0] set_byte(input logic [RW-1:0] r, input int i, input logic [7:0] b);
      logic [RW-1:0] m, t;
      m = RW'(8'hFF) << (8*i);
      t = RW'(b) << (8*i);
      return (r & ~m) | t;
   endfunction

   function automatic logic [RW-1:0] rand_mod(input logic [RW-1:0] base, input int k);
      logic [RW-1:0] r;
      r = base;
      for (int j = 0; j < k; j++) r = set_byte(r, int'($urandom_range(0, NB-1)), 8'($urandom));
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_rec(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      checks++;
      if (act !== exp) begin
         int k;
         k = 0;
         failures++;
         for (int i = NB-1; i >= 0; i--) if (get_byte(act, i) !== get_byte(exp, i)) k = i;
         $display("FAIL %s: first differing byte %0d got %02h want %02h", nm, k,
                  get_byte(act, k), get_byte(exp, k));
      end
   endtask

   task automatic chk_zero(input string p);
      check({p, "_cipo"}, 32'(cipo_data != '0), 32'(0));
      check({p, "_copi_rec"}, 32'(copi_rec != '0), 32'(0));
      check({p, "_rec_valid"}, 32'(rec_valid), 32'(0));
      check({p, "_evt_valid"}, 32'(evt_valid), 32'(0));
      check({p, "_evt_addr"}, 32'(evt_addr), 32'(0));
      check({p, "_evt_data"}, 32'(evt_data), 32'(0));
      check({p, "_evt_old"}, 32'(evt_old), 32'(0));
      check({p, "_scan_done"}, 32'(scan_done), 32'(0));
      check({p, "_overrun"}, 32'(overrun), 32'(0));
      check({p, "_xfer_cnt"}, 32'(xfer_cnt), 32'(0));
   endtask

   // Reference: every byte that differs from the last captured record is one event, ascending
   task automatic push_expect(input logic [RW-1:0] rec);
      for (int i = 0; i < NB; i++) begin
         logic [7:0] b;
         b = get_byte(rec, i);
         if (b != model_prev[i]) exp_evt.push_back({8'(i), b, model_prev[i]});
         model_prev[i] = b;
      end
      model_cnt = (model_cnt + 1) % 65536;
      exp_rec_q.push_back(rec);
      exp_cnt_q.push_back(16'(model_cnt));
   endtask

   task automatic req_stall(input int n);
      stall_len = n;
      stall_gen++;
   endtask

   task automatic xfer(input logic [RW-1:0] rec, input bit cap, input bit clr_fall);
      @(posedge clk); #2 spi_ss = 1'b0;
      repeat (3) @(posedge clk);
      #2 spi_busy = 1'b1;
      copi_data = rec;
      repeat (4) @(posedge clk);
      if (cap) push_expect(rec);
      #2 spi_busy = 1'b0;
      t_drop = $time;
      if (clr_fall) begin
         repeat (SS) @(posedge clk);
         #2 clr_overrun = 1'b1;
         @(posedge clk); #2 clr_overrun = 1'b0;
      end
      repeat (2) @(posedge clk);
      #2 spi_ss = 1'b1;
   endtask

   task automatic wait_done(input string nm, input bit chk_lat);
      int n;
      longint lat;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!scan_done && n < 3000);
      if (!scan_done) begin
         checks++;
         failures++;
         $display("FAIL %s: scan_done not seen within %0d cycles", nm, n);
      end else if (chk_lat) begin
         lat = ($time - t_drop - 3) / 10;
         checks++;
         if (lat < SS + 257 || lat > SS + 259) begin
            failures++;
            $display("FAIL %s: busy_fall to scan_done latency %0d want %0d", nm, lat, SS + 258);
         end
      end
   endtask

   task automatic wait_evt(input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!evt_valid && n < 1000);
      check(nm, 32'(evt_valid), 32'(1));
   endtask

   task automatic pulse_clr();
      @(posedge clk); #2 clr_overrun = 1'b1;
      @(posedge clk); #2 clr_overrun = 1'b0;
      @(negedge clk);
   endtask

   // Ready driver: honours a requested stall length counted in evt_valid cycles
   initial begin
      int last_gen = 0;
      int left = 0;
      evt_ready = 1'b1;
      forever begin
         @(posedge clk); #2;
         if (!rst_n) left = 0;
         if (stall_gen != last_gen) begin
            left = stall_len;
            last_gen = stall_gen;
         end
         if (left > 0) begin
            evt_ready = 1'b0;
            if (evt_valid) left--;
         end else begin
            evt_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a record, event or scan end
   initial begin
      bit held = 1'b0;
      logic [7:0] h_addr, h_data, h_old;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            held = 1'b0;
            continue;
         end
         if (held) check("evt_hold", 32'({evt_valid, evt_addr, evt_data, evt_old}),
                         32'({1'b1, h_addr, h_data, h_old}));
         held = evt_valid && !evt_ready;
         h_addr = evt_addr;
         h_data = evt_data;
         h_old = evt_old;
         if (held) stall_seen++;
         if (evt_valid && evt_ready) begin
            hs_cnt++;
            if (exp_evt.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL evt_extra: unexpected event addr %0d data %02h", evt_addr, evt_data);
            end else begin
               evt_t e;
               e = exp_evt.pop_front();
               check("evt_addr", 32'(evt_addr), 32'(e.addr));
               check("evt_data", 32'(evt_data), 32'(e.data));
               check("evt_old", 32'(evt_old), 32'(e.old));
            end
         end
         if (rec_valid) begin
            if (exp_rec_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rec_extra: rec_valid with no capture expected");
            end else begin
               logic [RW-1:0] er;
               er = exp_rec_q.pop_front();
               chk_rec("rec_data", copi_rec, er);
               check("rec_xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt_q.pop_front()));
            end
         end
         if (scan_done) check("scan_evts_left", 32'(exp_evt.size()), 32'(0));
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [RW-1:0] rec1, recC, recD, recE, recZ, cur, r;
      int hs0;
      for (int i = 0; i < NB; i++) model_prev[i] = 8'h00;
      rst_n = 1'b1; spi_ss = 1'b1; spi_busy = 1'b0; clr_overrun = 1'b0;
      copi_data = '0; tx_data = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("por");

      tx_data = {NB{8'hA5}};
      @(posedge clk); #2 rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      chk_rec("cipo_load", cipo_data, {NB{8'hA5}});
      @(posedge clk); #2 spi_ss = 1'b0;
      repeat (SS + 1) @(posedge clk);
      #2 tx_data = '0;
      repeat (5) @(negedge clk);
      chk_rec("cipo_frozen", cipo_data, {NB{8'hA5}});
      @(posedge clk); #2 spi_ss = 1'b1;
      repeat (SS + 2) @(negedge clk);
      chk_rec("cipo_reload", cipo_data, '0);

      rec1 = set_byte(set_byte('0, 3, 8'h12), 200, 8'h34);
      xfer(rec1, 1'b1, 1'b0);
      wait_done("lat_first", 1'b1);
      xfer(rec1, 1'b1, 1'b0);
      wait_done("lat_same", 1'b1);

      recC = set_byte(rec1, 0, 8'h55);
      stall_seen = 0;
      hs0 = hs_cnt;
      req_stall(10);
      xfer(recC, 1'b1, 1'b0);
      wait_done("done_stall", 1'b0);
      check("stall_cycles", 32'(stall_seen), 32'(10));
      check("stall_handshakes", 32'(hs_cnt - hs0), 32'(1));

      recD = set_byte(recC, 0, 8'h66);
      req_stall(40);
      xfer(recD, 1'b1, 1'b0);
      wait_evt("evt_before_drop");
      xfer(set_byte(recD, 9, 8'h99), 1'b0, 1'b0);
      repeat (SS + 1) @(negedge clk);
      check("overrun_set", 32'(overrun), 32'(1));
      check("cnt_after_drop", 32'(xfer_cnt), 32'(model_cnt));
      wait_done("done_overrun", 1'b0);
      pulse_clr();
      check("overrun_clr", 32'(overrun), 32'(0));

      recE = set_byte(recD, 0, 8'h77);
      req_stall(40);
      xfer(recE, 1'b1, 1'b0);
      wait_evt("evt_before_drop2");
      xfer(set_byte(recE, 77, 8'hC3), 1'b0, 1'b1);
      @(negedge clk);
      check("overrun_set_wins", 32'(overrun), 32'(1));
      check("cnt_after_drop2", 32'(xfer_cnt), 32'(model_cnt));
      wait_done("done_overrun2", 1'b0);
      pulse_clr();
      check("overrun_clr2", 32'(overrun), 32'(0));

      cur = recE;
      rand_ready = 1'b1;
      for (int t = 0; t < 3; t++) begin
         r = rand_mod(cur, int'($urandom_range(0, 6)));
         xfer(r, 1'b1, 1'b0);
         wait_done("done_rand", 1'b0);
         cur = r;
      end
      rand_ready = 1'b0;

      @(posedge clk); #2 spi_ss = 1'b0;
      repeat (5) @(posedge clk);
      #2 spi_ss = 1'b1;
      repeat (10) @(negedge clk);
      check("abort_cnt", 32'(xfer_cnt), 32'(model_cnt));

      r = rand_mod(cur, 3);
      r = set_byte(r, 5, ~get_byte(cur, 5));
      req_stall(100);
      xfer(r, 1'b1, 1'b0);
      wait_evt("evt_before_reset");
      #3 rst_n = 1'b0;
      exp_evt.delete();
      exp_rec_q.delete();
      exp_cnt_q.delete();
      for (int i = 0; i < NB; i++) model_prev[i] = 8'h00;
      model_cnt = 0;
      #1 chk_zero("midrst");
      repeat (2) @(posedge clk);
      #4 rst_n = 1'b1;

      recZ = set_byte(set_byte('0, 1, 8'h01), 255, 8'hFF);
      xfer(recZ, 1'b1, 1'b0);
      wait_done("lat_after_reset", 1'b1);

      repeat (4) @(negedge clk);
      check("evt_queue_empty", 32'(exp_evt.size()), 32'(0));
      check("rec_queue_empty", 32'(exp_rec_q.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/spi_record_mailbox.md
Name: spi_record_mailbox

Overview:
- Sysclock-domain consumer of the SPI peripheral driver's 256-byte user records.
- Takes the raw COPI record and the busy/ss lines, which are asynchronous to sysclock, and publishes a stable copy of the record after each completed transfer.
- Scans the new record against the previous one and streams one change event per modified byte over a valid/ready handshake.
- Drives the driver's CIPO record from a user TX record, and holds that value frozen while the Arduino is selected.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the ss/busy synchronisers (minimum 2)
REC_BYTES, 256, record length in bytes; record width = 8*REC_BYTES

Ports:
sysclock  in  1  system clock
sysreset  in  1  asynchronous reset, active-low
spi_ss  in  1  raw SPI slave-select, active-low, async
spi_busy  in  1  driver busy (XCHG phase), async
copi_data  in  2048  driver COPI record, stable whenever spi_busy=0
cipo_data  out  2048  record to driver CIPO input
tx_data  in  2048  user record to be sent to the Arduino
copi_rec  out  2048  published COPI record
rec_valid  out  1  one-cycle pulse when copi_rec has been updated
evt_valid  out  1  change event valid
evt_ready  in  1  change event accepted
evt_addr  out  8  byte index of the changed byte
evt_data  out  8  new byte value
evt_old  out  8  previous byte value
scan_done  out  1  one-cycle pulse at the end of a scan
overrun  out  1  sticky flag: a transfer completed while a scan was still running
clr_overrun  in  1  clears overrun
xfer_cnt  out  16  count of captured transfers, wraps modulo 2^16

Behaviour:
- Reset (sysreset=0, asynchronous):
  - All outputs are 0 and the state is IDLE.
  - Internal registers are cleared: old_rec=0, copi_rec=0, idx=0.
  - The synchroniser chains reset to the idle level: ss_s=1, busy_s=0.
  - Reset mid-scan aborts the scan with no further events.
- Synchronisers:
  - ss_s and busy_s are the last stage of SYNC_STAGES-deep chains.
  - busy_fall = (previous busy_s=1 AND current busy_s=0).
- cipo_data:
  - While ss_s=1, cipo_data <= tx_data every cycle.
  - While ss_s=0, cipo_data holds its value.
  - It therefore stays frozen for the whole selected window, including the 16 offset bits.
- Byte i of any record occupies bits [8i+7:8i].
- State machine IDLE / CAPTURE / SCAN / DONE:
  - IDLE: on busy_fall go to CAPTURE. Otherwise stay.
  - CAPTURE (1 cycle): old_rec<=copi_rec; copi_rec<=copi_data; xfer_cnt++; idx<=0; go to SCAN.
    - rec_valid pulses in the first SCAN cycle.
    - copi_data is sampled ≥SYNC_STAGES cycles after busy falls, so it is stable.
  - SCAN:
    - If copi_rec byte idx equals old_rec byte idx, advance idx in the same cycle (1 byte per cycle).
    - Otherwise assert evt_valid with evt_addr=idx, evt_data=new byte, evt_old=old byte.
    - Hold these outputs unchanged until evt_ready=1. The handshake completes in the cycle where evt_valid AND evt_ready are both 1; idx advances after that cycle.
    - evt_valid may not deassert without a handshake.
    - After byte REC_BYTES-1 is handled, go to DONE.
  - DONE (1 cycle): scan_done=1; go to IDLE.
- Latency:
  - Unchanged record: busy_fall to scan_done = 1 + 256 + 1 cycles.
  - Each event adds its ready-stall cycles.
- Overrun:
  - A busy_fall seen in CAPTURE, SCAN or DONE sets overrun.
  - That record is dropped: no capture, no xfer_cnt increment.
  - The current scan continues unaffected.
- clr_overrun clears overrun. If set and clear occur in the same cycle, set wins.
- First transfer after reset is compared against old_rec=0, so every nonzero byte produces an event.
- Aborted transfer (ss rises with busy never asserted) produces no busy_fall and no capture.
- xfer_cnt wraps 0xFFFF→0x0000.

Test Plan:
- Reset, then tx_data=0xA5 repeated; ss high → cipo_data=0xA5.. after 1 cycle. Drop ss, change tx_data to 0x00 → cipo_data stays 0xA5.. until ss_s rises.
- Transfer with copi_data byte3=0x12 and byte200=0x34, all others 0, evt_ready=1 → rec_valid once; events (3,0x12,0x00) then (200,0x34,0x00); scan_done at busy_fall+SYNC_STAGES+258 (±1); xfer_cnt=1.
- Repeat the identical record → zero events, scan_done after 258 cycles, xfer_cnt=2.
- Change byte0 to 0x55 with evt_ready held low for 10 cycles → evt_valid/addr/data/old stable for 10 cycles; exactly one handshake.
- Second busy_fall during a stalled scan → overrun=1, xfer_cnt unchanged, original scan completes. clr_overrun together with a new set → overrun stays 1.
- Assert sysreset mid-scan with evt_valid=1 → all outputs 0 immediately; next transfer is compared against a zero old_rec.
